// File: rtl/branch_resolve_pkg.sv
// Shared constants for the branch/trap resolve stage: CSR addresses, mcause codes,
// branch funct3 encodings and the per-instruction resolution class.
package branch_resolve_pkg;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;

  localparam logic [31:0] CAUSE_MISALIGNED_FETCH = 32'd0;
  localparam logic [31:0] CAUSE_ILLEGAL          = 32'd2;
  localparam logic [31:0] CAUSE_BREAKPOINT       = 32'd3;
  localparam logic [31:0] CAUSE_ECALL_M          = 32'd11;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    RES_NONE,
    RES_NORMAL,
    RES_TRAP,
    RES_MRET
  } resolve_e;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/branch_resolve_compare.sv
// Combinational branch condition evaluator: funct3 selects the rs1/rs2 compare,
// reserved encodings are flagged as illegal and never report a true condition.
module branch_compare #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            cond,
  output logic            illegal
);
  import branch_resolve_pkg::*;

  logic eq;
  logic lt_s;
  logic lt_u;

  assign eq   = (rs1 == rs2);
  assign lt_s = ($signed(rs1) < $signed(rs2));
  assign lt_u = (rs1 < rs2);

  always_comb begin
    cond    = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-to-memory resolve stage: computes branch/jump outcome, raises traps and
// MRET, owns mtvec/mepc/mcause and registers the mb_if__* feedback to fetch.
module branch_resolve #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0004,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kill,
  input  logic            ex_mb__valid,
  input  logic [XLEN-1:0] ex_mb__pc,
  input  logic            ex_mb__is_branch,
  input  logic            ex_mb__is_jal,
  input  logic            ex_mb__is_jalr,
  input  logic [2:0]      ex_mb__funct3,
  input  logic [XLEN-1:0] ex_mb__rs1,
  input  logic [XLEN-1:0] ex_mb__rs2,
  input  logic [XLEN-1:0] ex_mb__imm,
  input  logic            ex_mb__ecall,
  input  logic            ex_mb__ebreak,
  input  logic            ex_mb__illegal,
  input  logic            ex_mb__mret,
  input  logic            ex_mb__predict_taken,
  input  logic [XLEN-1:0] ex_mb__predict_target,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic [XLEN-1:0] mb_if__pc,
  output logic [XLEN-1:0] mb_if__pc_4,
  output logic [XLEN-1:0] mb_if__jump_target,
  output logic            mb_if__branch_taken,
  output logic            mb_if__trap_taken,
  output logic            mb_if__predict_taken,
  output logic [XLEN-1:0] mb_if__predict_target
);
  import branch_resolve_pkg::*;

  logic            v;
  logic            cond;
  logic            f3_illegal;
  logic            taken;
  logic            illegal_any;
  logic            misaligned;
  logic            exc;
  logic [XLEN-1:0] pc_4;
  logic [XLEN-1:0] target_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] cause;
  resolve_e        res;

  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] pc_4_d, pc_4_q;
  logic [XLEN-1:0] jump_target_d, jump_target_q;
  logic            branch_taken_d, branch_taken_q;
  logic            trap_taken_d, trap_taken_q;
  logic            predict_taken_d, predict_taken_q;
  logic [XLEN-1:0] predict_target_d, predict_target_q;
  logic [XLEN-1:0] mtvec_d, mtvec_q;
  logic [XLEN-1:0] mepc_d, mepc_q;
  logic [XLEN-1:0] mcause_d, mcause_q;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .funct3  (ex_mb__funct3),
    .rs1     (ex_mb__rs1),
    .rs2     (ex_mb__rs2),
    .cond    (cond),
    .illegal (f3_illegal)
  );

  always_comb begin
    v           = ex_mb__valid && !kill;
    pc_4        = ex_mb__pc + XLEN'(4);
    target_sum  = ex_mb__is_jalr ? (ex_mb__rs1 + ex_mb__imm) : (ex_mb__pc + ex_mb__imm);
    target      = ex_mb__is_jalr ? {target_sum[XLEN-1:1], 1'b0} : target_sum;
    taken       = ex_mb__is_jal || ex_mb__is_jalr || (ex_mb__is_branch && cond);
    illegal_any = ex_mb__illegal || (ex_mb__is_branch && f3_illegal);
    misaligned  = taken && target[1];

    exc   = 1'b1;
    cause = CAUSE_MISALIGNED_FETCH;
    if (illegal_any)        cause = CAUSE_ILLEGAL;
    else if (misaligned)    cause = CAUSE_MISALIGNED_FETCH;
    else if (ex_mb__ecall)  cause = CAUSE_ECALL_M;
    else if (ex_mb__ebreak) cause = CAUSE_BREAKPOINT;
    else                    exc   = 1'b0;

    if (!v)               res = RES_NONE;
    else if (exc)         res = RES_TRAP;
    else if (ex_mb__mret) res = RES_MRET;
    else                  res = RES_NORMAL;
  end

  // Redirects (trap/MRET) zero predict_taken and echo the redirect target so the
  // BTB never trains on them and fetch's mispredict compare stays quiet.
  always_comb begin
    pc_d             = '0;
    pc_4_d           = XLEN'(4);
    jump_target_d    = '0;
    branch_taken_d   = 1'b0;
    trap_taken_d     = 1'b0;
    predict_taken_d  = 1'b0;
    predict_target_d = '0;
    unique case (res)
      RES_TRAP: begin
        pc_d             = ex_mb__pc;
        pc_4_d           = pc_4;
        trap_taken_d     = 1'b1;
        jump_target_d    = mtvec_q;
        predict_target_d = mtvec_q;
      end
      RES_MRET: begin
        pc_d             = ex_mb__pc;
        pc_4_d           = pc_4;
        trap_taken_d     = 1'b1;
        jump_target_d    = mepc_q;
        predict_target_d = mepc_q;
      end
      RES_NORMAL: begin
        pc_d             = ex_mb__pc;
        pc_4_d           = pc_4;
        branch_taken_d   = taken;
        jump_target_d    = taken ? target : pc_4;
        predict_taken_d  = ex_mb__predict_taken;
        predict_target_d = ex_mb__predict_target;
      end
      default: ;
    endcase
  end

  // Trap capture is applied after the CSR write so it wins on mepc/mcause.
  always_comb begin
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
    if (csr_we) begin
      case (csr_addr)
        CSR_MTVEC:  mtvec_d  = word_align(csr_wdata);
        CSR_MEPC:   mepc_d   = word_align(csr_wdata);
        CSR_MCAUSE: mcause_d = csr_wdata;
        default: ;
      endcase
    end
    if (res == RES_TRAP) begin
      mepc_d   = ex_mb__pc;
      mcause_d = cause;
    end
  end

  always_comb begin
    case (csr_addr)
      CSR_MTVEC:  csr_rdata = mtvec_q;
      CSR_MEPC:   csr_rdata = mepc_q;
      CSR_MCAUSE: csr_rdata = mcause_q;
      default:    csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= '0;
      pc_4_q           <= '0;
      jump_target_q    <= '0;
      branch_taken_q   <= 1'b0;
      trap_taken_q     <= 1'b0;
      predict_taken_q  <= 1'b0;
      predict_target_q <= '0;
      mtvec_q          <= word_align(MTVEC_RESET);
      mepc_q           <= '0;
      mcause_q         <= '0;
    end else begin
      pc_q             <= pc_d;
      pc_4_q           <= pc_4_d;
      jump_target_q    <= jump_target_d;
      branch_taken_q   <= branch_taken_d;
      trap_taken_q     <= trap_taken_d;
      predict_taken_q  <= predict_taken_d;
      predict_target_q <= predict_target_d;
      mtvec_q          <= mtvec_d;
      mepc_q           <= mepc_d;
      mcause_q         <= mcause_d;
    end
  end

  assign mb_if__pc             = pc_q;
  assign mb_if__pc_4           = pc_4_q;
  assign mb_if__jump_target    = jump_target_q;
  assign mb_if__branch_taken   = branch_taken_q;
  assign mb_if__trap_taken     = trap_taken_q;
  assign mb_if__predict_taken  = predict_taken_q;
  assign mb_if__predict_target = predict_target_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table, hand-written CSR and
// reset sequences, then randomized stimulus against a behavioural model.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        kill;
  logic        ex_mb__valid;
  logic [31:0] ex_mb__pc;
  logic        ex_mb__is_branch, ex_mb__is_jal, ex_mb__is_jalr;
  logic [2:0]  ex_mb__funct3;
  logic [31:0] ex_mb__rs1, ex_mb__rs2, ex_mb__imm;
  logic        ex_mb__ecall, ex_mb__ebreak, ex_mb__illegal, ex_mb__mret;
  logic        ex_mb__predict_taken;
  logic [31:0] ex_mb__predict_target;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic [31:0] mb_if__pc, mb_if__pc_4, mb_if__jump_target, mb_if__predict_target;
  logic        mb_if__branch_taken, mb_if__trap_taken, mb_if__predict_taken;

  int checks = 0;
  int errors = 0;

  branch_resolve #(.MTVEC_RESET(32'h0000_0004), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .kill(kill),
    .ex_mb__valid(ex_mb__valid), .ex_mb__pc(ex_mb__pc),
    .ex_mb__is_branch(ex_mb__is_branch), .ex_mb__is_jal(ex_mb__is_jal),
    .ex_mb__is_jalr(ex_mb__is_jalr), .ex_mb__funct3(ex_mb__funct3),
    .ex_mb__rs1(ex_mb__rs1), .ex_mb__rs2(ex_mb__rs2), .ex_mb__imm(ex_mb__imm),
    .ex_mb__ecall(ex_mb__ecall), .ex_mb__ebreak(ex_mb__ebreak),
    .ex_mb__illegal(ex_mb__illegal), .ex_mb__mret(ex_mb__mret),
    .ex_mb__predict_taken(ex_mb__predict_taken),
    .ex_mb__predict_target(ex_mb__predict_target),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .mb_if__pc(mb_if__pc), .mb_if__pc_4(mb_if__pc_4),
    .mb_if__jump_target(mb_if__jump_target),
    .mb_if__branch_taken(mb_if__branch_taken), .mb_if__trap_taken(mb_if__trap_taken),
    .mb_if__predict_taken(mb_if__predict_taken),
    .mb_if__predict_target(mb_if__predict_target)
  );

  always #5 clk = ~clk;

  // cls: 0 none, 1 conditional branch, 2 JAL, 3 JALR
  typedef struct {
    logic        valid, kill;
    logic [1:0]  cls;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic        ecall, ebreak, ill, mret, pt;
    logic [31:0] ptgt;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
  } in_t;

  typedef struct {
    logic        bt, tt, pt;
    logic [31:0] pc, pc4, jt, ptgt;
  } out_t;

  typedef struct {
    in_t         i;
    out_t        o;
    logic [31:0] rd;
  } vec_t;

  logic [31:0] m_mtvec, m_mepc, m_mcause;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input out_t e);
    chk1({tag, ".branch_taken"},  mb_if__branch_taken,   e.bt);
    chk1({tag, ".trap_taken"},    mb_if__trap_taken,     e.tt);
    chk1({tag, ".predict_taken"}, mb_if__predict_taken,  e.pt);
    chk ({tag, ".pc"},            mb_if__pc,             e.pc);
    chk ({tag, ".pc_4"},          mb_if__pc_4,           e.pc4);
    chk ({tag, ".jump_target"},   mb_if__jump_target,    e.jt);
    chk ({tag, ".predict_tgt"},   mb_if__predict_target, e.ptgt);
  endtask

  function automatic in_t idle_in();
    in_t t;
    t = '{valid: 1'b0, kill: 1'b0, cls: 2'd0, f3: 3'd0, pc: 32'd0, rs1: 32'd0,
          rs2: 32'd0, imm: 32'd0, ecall: 1'b0, ebreak: 1'b0, ill: 1'b0, mret: 1'b0,
          pt: 1'b0, ptgt: 32'd0, we: 1'b0, addr: 12'h342, wdata: 32'd0};
    return t;
  endfunction

  function automatic in_t ctl(input logic [1:0] cls, input logic [2:0] f3,
                              input logic [31:0] pc, rs1, rs2, imm);
    in_t t;
    t = idle_in();
    t.valid = 1'b1; t.cls = cls; t.f3 = f3;
    t.pc = pc; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
    return t;
  endfunction

  function automatic vec_t mkv(input in_t i, input logic bt, tt, pt,
                               input logic [31:0] jt, pc4, ptgt,
                               input logic [11:0] rd_addr, input logic [31:0] rd);
    vec_t r;
    r.i      = i;
    r.i.addr = rd_addr;
    r.o.bt = bt; r.o.tt = tt; r.o.pt = pt;
    r.o.jt = jt; r.o.pc4 = pc4; r.o.ptgt = ptgt;
    r.o.pc = (i.valid && !i.kill) ? i.pc : 32'd0;
    r.rd   = rd;
    return r;
  endfunction

  task automatic drive(input in_t t);
    ex_mb__valid          = t.valid;
    kill                  = t.kill;
    ex_mb__is_branch      = (t.cls == 2'd1);
    ex_mb__is_jal         = (t.cls == 2'd2);
    ex_mb__is_jalr        = (t.cls == 2'd3);
    ex_mb__funct3         = t.f3;
    ex_mb__pc             = t.pc;
    ex_mb__rs1            = t.rs1;
    ex_mb__rs2            = t.rs2;
    ex_mb__imm            = t.imm;
    ex_mb__ecall          = t.ecall;
    ex_mb__ebreak         = t.ebreak;
    ex_mb__illegal        = t.ill;
    ex_mb__mret           = t.mret;
    ex_mb__predict_taken  = t.pt;
    ex_mb__predict_target = t.ptgt;
    csr_we                = t.we;
    csr_addr              = t.addr;
    csr_wdata             = t.wdata;
  endtask

  task automatic step(input in_t t);
    drive(t);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_rd(input logic [11:0] a);
    if (a == 12'h305) return m_mtvec;
    if (a == 12'h341) return m_mepc;
    if (a == 12'h342) return m_mcause;
    return 32'd0;
  endfunction

  // Behavioural reference: architectural rules evaluated directly on the inputs.
  task automatic model(input in_t t, output out_t o);
    logic [31:0] tgt, n_mtvec, n_mepc, n_mcause;
    logic        c, bad, tk, trap;
    int          cause;
    o = '{bt: 1'b0, tt: 1'b0, pt: 1'b0, pc: 32'd0, pc4: 32'd4, jt: 32'd0, ptgt: 32'd0};
    n_mtvec = m_mtvec; n_mepc = m_mepc; n_mcause = m_mcause;
    if (t.we && t.addr == 12'h305) n_mtvec  = t.wdata & 32'hFFFF_FFFC;
    if (t.we && t.addr == 12'h341) n_mepc   = t.wdata & 32'hFFFF_FFFC;
    if (t.we && t.addr == 12'h342) n_mcause = t.wdata;
    if (t.valid && !t.kill) begin
      o.pc = t.pc; o.pc4 = t.pc + 32'd4;
      c = 1'b0; bad = 1'b0;
      if (t.cls == 2'd1) begin
        case (t.f3)
          3'd0: c = (t.rs1 == t.rs2);
          3'd1: c = (t.rs1 != t.rs2);
          3'd4: c = ($signed(t.rs1) <  $signed(t.rs2));
          3'd5: c = ($signed(t.rs1) >= $signed(t.rs2));
          3'd6: c = (t.rs1 <  t.rs2);
          3'd7: c = (t.rs1 >= t.rs2);
          default: bad = 1'b1;
        endcase
      end
      tgt  = (t.cls == 2'd3) ? ((t.rs1 + t.imm) & 32'hFFFF_FFFE) : (t.pc + t.imm);
      tk   = (t.cls == 2'd2) || (t.cls == 2'd3) || ((t.cls == 2'd1) && c);
      trap = 1'b1;
      if (t.ill || bad)         cause = 2;
      else if (tk && tgt[1])    cause = 0;
      else if (t.ecall)         cause = 11;
      else if (t.ebreak)        cause = 3;
      else begin trap = 1'b0; cause = 0; end
      if (trap) begin
        o.tt = 1'b1; o.jt = m_mtvec; o.ptgt = m_mtvec;
        n_mepc = t.pc; n_mcause = 32'(cause);
      end else if (t.mret) begin
        o.tt = 1'b1; o.jt = m_mepc; o.ptgt = m_mepc;
      end else begin
        o.bt = tk; o.jt = tk ? tgt : o.pc4; o.pt = t.pt; o.ptgt = t.ptgt;
      end
    end
    m_mtvec = n_mtvec; m_mepc = n_mepc; m_mcause = n_mcause;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[$];
    in_t  t;
    out_t e;

    drive(idle_in());
    #2 rst_n = 1'b0;
    #1;
    chk1("rst.branch_taken", mb_if__branch_taken, 1'b0);
    chk1("rst.trap_taken",   mb_if__trap_taken,   1'b0);
    chk ("rst.pc_4",         mb_if__pc_4,         32'd0);
    csr_addr = 12'h305; #1;
    chk ("rst.mtvec",        csr_rdata,           32'h4);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // ---------------- directed table (mtvec stays 0x4) ----------------
    t = ctl(2'd1, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20);
    tbl.push_back(mkv(t, 1, 0, 0, 32'h120, 32'h104, 32'h0, 12'h342, 32'd0));
    t = ctl(2'd1, 3'b110, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
    tbl.push_back(mkv(t, 0, 0, 0, 32'h204, 32'h204, 32'h0, 12'h342, 32'd0));
    t = ctl(2'd1, 3'b100, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40);
    tbl.push_back(mkv(t, 1, 0, 0, 32'h240, 32'h204, 32'h0, 12'h342, 32'd0));
    t = ctl(2'd3, 3'b000, 32'h300, 32'h203, 32'd0, 32'd0); t.pt = 1; t.ptgt = 32'h203;
    tbl.push_back(mkv(t, 0, 1, 0, 32'h4, 32'h304, 32'h4, 12'h341, 32'h300));
    t = ctl(2'd2, 3'b000, 32'h400, 32'd0, 32'd0, 32'h8); t.kill = 1; t.pt = 1; t.ptgt = 32'h408;
    tbl.push_back(mkv(t, 0, 0, 0, 32'h0, 32'h4, 32'h0, 12'h341, 32'h300));
    t = idle_in(); t.pc = 32'h123; t.cls = 2'd2; t.pt = 1; t.ptgt = 32'h55;
    tbl.push_back(mkv(t, 0, 0, 0, 32'h0, 32'h4, 32'h0, 12'h305, 32'h4));
    t = ctl(2'd1, 3'b001, 32'h500, 32'd3, 32'd3, 32'h10); t.pt = 1; t.ptgt = 32'h510;
    tbl.push_back(mkv(t, 0, 0, 1, 32'h504, 32'h504, 32'h510, 12'h342, 32'd0));
    t = ctl(2'd1, 3'b010, 32'h600, 32'd1, 32'd1, 32'h10);
    tbl.push_back(mkv(t, 0, 1, 0, 32'h4, 32'h604, 32'h4, 12'h342, 32'd2));
    t = ctl(2'd1, 3'b101, 32'h700, 32'h8000_0000, 32'd0, 32'h40);
    tbl.push_back(mkv(t, 0, 0, 0, 32'h704, 32'h704, 32'h0, 12'h342, 32'd2));
    t = ctl(2'd1, 3'b111, 32'h800, 32'h8000_0000, 32'd0, 32'hFFFF_FFFC);
    tbl.push_back(mkv(t, 1, 0, 0, 32'h7FC, 32'h804, 32'h0, 12'h341, 32'h600));
    t = ctl(2'd2, 3'b000, 32'hFFFF_FFF0, 32'd0, 32'd0, 32'h20);
    tbl.push_back(mkv(t, 1, 0, 0, 32'h10, 32'hFFFF_FFF4, 32'h0, 12'h342, 32'd2));
    t = ctl(2'd2, 3'b000, 32'h900, 32'd0, 32'd0, 32'h6);
    tbl.push_back(mkv(t, 0, 1, 0, 32'h4, 32'h904, 32'h4, 12'h342, 32'd0));
    t = ctl(2'd0, 3'b000, 32'hA00, 32'd0, 32'd0, 32'd0); t.ill = 1; t.ecall = 1;
    tbl.push_back(mkv(t, 0, 1, 0, 32'h4, 32'hA04, 32'h4, 12'h342, 32'd2));
    t = ctl(2'd0, 3'b000, 32'hB00, 32'd0, 32'd0, 32'd0); t.ebreak = 1;
    tbl.push_back(mkv(t, 0, 1, 0, 32'h4, 32'hB04, 32'h4, 12'h342, 32'd3));
    t = ctl(2'd0, 3'b000, 32'hC00, 32'd0, 32'd0, 32'd0); t.ecall = 1; t.ebreak = 1;
    tbl.push_back(mkv(t, 0, 1, 0, 32'h4, 32'hC04, 32'h4, 12'h342, 32'd11));
    t = ctl(2'd3, 3'b000, 32'hD00, 32'h1001, 32'd0, 32'h7);
    tbl.push_back(mkv(t, 1, 0, 0, 32'h1008, 32'hD04, 32'h0, 12'h341, 32'hC00));
    t = ctl(2'd3, 3'b000, 32'hE00, 32'h1000, 32'd0, 32'h5);
    tbl.push_back(mkv(t, 1, 0, 0, 32'h1004, 32'hE04, 32'h0, 12'h342, 32'd11));
    t = ctl(2'd2, 3'b000, 32'hF00, 32'd0, 32'd0, 32'h2); t.ecall = 1;
    tbl.push_back(mkv(t, 0, 1, 0, 32'h4, 32'hF04, 32'h4, 12'h342, 32'd0));

    for (int unsigned k = 0; k < tbl.size(); k++) begin
      step(tbl[k].i);
      chk_out($sformatf("vec%0d", k), tbl[k].o);
      chk($sformatf("vec%0d.csr", k), csr_rdata, tbl[k].rd);
    end

    // ---------------- CSR / trap / MRET sequences ----------------
    t = idle_in(); t.we = 1; t.addr = 12'h305; t.wdata = 32'h1003;
    step(t);
    chk("mtvec_wr", csr_rdata, 32'h1000);
    t = ctl(2'd0, 3'b000, 32'h80, 32'd0, 32'd0, 32'd0); t.ecall = 1; t.addr = 12'h341;
    step(t);
    chk1("ecall.trap", mb_if__trap_taken, 1'b1);
    chk ("ecall.jt",   mb_if__jump_target, 32'h1000);
    chk ("ecall.mepc", csr_rdata, 32'h80);
    csr_addr = 12'h342; #1;
    chk ("ecall.mcause", csr_rdata, 32'd11);
    t = ctl(2'd0, 3'b000, 32'h84, 32'd0, 32'd0, 32'd0); t.mret = 1;
    step(t);
    chk1("mret.trap", mb_if__trap_taken, 1'b1);
    chk1("mret.bt",   mb_if__branch_taken, 1'b0);
    chk ("mret.jt",   mb_if__jump_target, 32'h80);

    t = ctl(2'd0, 3'b000, 32'h90, 32'd0, 32'd0, 32'd0); t.ebreak = 1;
    t.we = 1; t.addr = 12'h341; t.wdata = 32'h555;
    step(t);
    chk("trap_vs_wr.mepc", csr_rdata, 32'h90);
    t = ctl(2'd0, 3'b000, 32'hA0, 32'd0, 32'd0, 32'd0); t.ebreak = 1;
    t.we = 1; t.addr = 12'h305; t.wdata = 32'h3000;
    step(t);
    chk("trap_old_mtvec.jt", mb_if__jump_target, 32'h1000);
    chk("trap_vs_wr.mtvec",  csr_rdata, 32'h3000);

    t = idle_in(); t.we = 1; t.addr = 12'h341; t.wdata = 32'h1237;
    step(t); chk("mepc_wr", csr_rdata, 32'h1234);
    t = idle_in(); t.we = 1; t.addr = 12'h342; t.wdata = 32'hDEAD_BEEF;
    step(t); chk("mcause_wr", csr_rdata, 32'hDEAD_BEEF);
    t = idle_in(); t.we = 1; t.addr = 12'h300; t.wdata = 32'hFFFF;
    step(t); chk("other_csr", csr_rdata, 32'd0);
    csr_addr = 12'h305; #1;
    chk("mtvec_kept", csr_rdata, 32'h3000);

    // ---------------- reset pulse mid-stream ----------------
    t = ctl(2'd2, 3'b000, 32'h40, 32'd0, 32'd0, 32'h10);
    step(t);
    chk1("pre_rst.bt", mb_if__branch_taken, 1'b1);
    chk ("pre_rst.jt", mb_if__jump_target, 32'h50);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst.bt", mb_if__branch_taken, 1'b0);
    chk ("async_rst.jt", mb_if__jump_target, 32'd0);
    chk ("async_rst.pc", mb_if__pc, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    t = idle_in(); t.addr = 12'h305;
    drive(t); #1;
    chk("post_rst.mtvec", csr_rdata, 32'h4);
    step(t);
    chk1("post_rst.bt", mb_if__branch_taken, 1'b0);
    chk1("post_rst.tt", mb_if__trap_taken, 1'b0);
    chk ("post_rst.pc_4", mb_if__pc_4, 32'd4);

    // ---------------- randomized vs model ----------------
    m_mtvec = 32'h4; m_mepc = 32'd0; m_mcause = 32'd0;
    for (int n = 0; n < 400; n++) begin
      t = idle_in();
      t.valid = ($urandom_range(0, 9) != 0);
      t.kill  = ($urandom_range(0, 9) == 0);
      t.cls   = 2'($urandom_range(0, 3));
      t.f3    = 3'($urandom_range(0, 7));
      t.pc    = $urandom() & 32'hFFFF_FFFC;
      case ($urandom_range(0, 2))
        0: begin t.rs1 = 32'($urandom_range(0, 3)); t.rs2 = 32'($urandom_range(0, 3)); end
        1: begin t.rs1 = $urandom(); t.rs2 = $urandom(); end
        default: begin t.rs1 = $urandom(); t.rs2 = t.rs1 ^ 32'h8000_0000; end
      endcase
      t.imm = $urandom();
      if ($urandom_range(0, 1) == 0) t.imm = t.imm & 32'hFFFF_FFFC;
      t.ecall  = ($urandom_range(0, 11) == 0);
      t.ebreak = ($urandom_range(0, 11) == 0);
      t.ill    = ($urandom_range(0, 15) == 0);
      t.mret   = ($urandom_range(0, 11) == 0);
      t.pt     = 1'($urandom_range(0, 1));
      t.ptgt   = $urandom();
      t.we     = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0: t.addr = 12'h305;
        1: t.addr = 12'h341;
        2: t.addr = 12'h342;
        default: t.addr = 12'h300;
      endcase
      t.wdata = $urandom();
      step(t);
      model(t, e);
      chk_out($sformatf("rnd%0d", n), e);
      chk($sformatf("rnd%0d.csr", n), csr_rdata, model_rd(t.addr));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
